// File: rtl/gf2m_409_pkg.sv
// gf2m_409_pkg
// Shared constants and types for the GF(2^409) reduction stage.
//   M          field degree (409)
//   K          middle term of the trinomial x^409 + x^87 + 1
//   PROD_W     width of an unreduced product (2*M-1 = 817)
//   M_MINUS_K  distance of the second fold image (322)
//   H_W        width needed to hold a bit index below PROD_W
//   state_t    reducer FSM states
package gf2m_409_pkg;

    localparam int M         = 409;
    localparam int K         = 87;
    localparam int PROD_W    = 2 * M - 1;
    localparam int M_MINUS_K = M - K;
    localparam int H_W       = 10;

    typedef enum logic [1:0] {
        IDLE,
        FOLD,
        DONE
    } state_t;

endpackage

// File: rtl/gf2m_fold_409.sv
// gf2m_fold_409
// Combinational single-chunk fold for reduction modulo x^409 + x^87 + 1.
// The CHUNK bits whose top bit sits at index h are cleared, and each one
// is replaced by its two images x^(i-409) and x^(i-322).
//   acc_in   [816:0]  accumulator before this fold
//   h        [9:0]    index of the highest bit of the chunk being folded
//   acc_out  [816:0]  accumulator after this fold
module gf2m_fold_409
    import gf2m_409_pkg::*;
#(
    parameter int CHUNK = 68
) (
    input  logic [PROD_W-1:0] acc_in,
    input  logic [H_W-1:0]    h,
    output logic [PROD_W-1:0] acc_out
);

    localparam logic [PROD_W-1:0] CHUNK_MASK = PROD_W'({CHUNK{1'b1}});

    logic [H_W-1:0]    lo;
    logic [CHUNK-1:0]  chunk_bits;
    logic [PROD_W-1:0] t_ext;

    // Both images land strictly below the chunk being cleared (CHUNK is
    // at most 322), so clearing and XOR-ing the images never interact.
    // The lowest chunk ever folded starts at bit 409, so neither shift
    // amount can go negative.
    always_comb begin
        lo         = h - H_W'(CHUNK - 1);
        chunk_bits = acc_in[lo +: CHUNK];
        t_ext      = PROD_W'(chunk_bits);
        acc_out    = (acc_in & ~(CHUNK_MASK << lo))
                   ^ (t_ext << (lo - H_W'(M)))
                   ^ (t_ext << (lo - H_W'(M_MINUS_K)));
    end

endmodule

// File: rtl/gf2m_reduce_409.sv
// gf2m_reduce_409
// Iterative reduction of an 817-bit GF(2) product modulo
// f(x) = x^409 + x^87 + 1, folding CHUNK high-order bits per clock,
// top-down, over NFOLD = 408/CHUNK cycles.
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   product present on in_prod
//   in_ready   idle, will accept in_prod this cycle
//   in_prod    [816:0] product c(x), bit i = coefficient of x^i
//   out_valid  out_res holds a finished residue
//   out_ready  consumer takes out_res
//   out_res    [408:0] c(x) mod f(x)
//   busy       operation in progress (FOLD or DONE)
module gf2m_reduce_409
    import gf2m_409_pkg::*;
#(
    parameter int CHUNK = 68
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [M-1:0]      out_res,
    output logic              busy
);

    localparam int NFOLD = (PROD_W - M) / CHUNK;
    localparam int CNT_W = $clog2(NFOLD + 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [PROD_W-1:0] acc;
    logic [PROD_W-1:0] acc_next;
    logic [H_W-1:0]    h;

    // Top bit of the chunk folded this cycle: walks down from 816 by
    // CHUNK per fold so every image bit is picked up by a later fold.
    always_comb begin
        h = H_W'(PROD_W - 1) - H_W'(cnt) * H_W'(CHUNK);
    end

    gf2m_fold_409 #(
        .CHUNK (CHUNK)
    ) u_fold (
        .acc_in  (acc),
        .h       (h),
        .acc_out (acc_next)
    );

    // Control FSM with registered handshake outputs. The residue is
    // captured from the last fold's output, at which point the upper
    // half of the accumulator has been cleared. in_valid is only looked
    // at in IDLE, so requests while busy are dropped without sampling.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_res   <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc      <= in_prod;
                        cnt      <= '0;
                        state    <= FOLD;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                FOLD: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(NFOLD - 1)) begin
                        out_res   <= acc_next[M-1:0];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gf2m_reduce_409.sv
// tb_gf2m_reduce_409
// Self-checking bench for gf2m_reduce_409: directed corner products,
// random products and random carry-less products compared against a
// bitwise long-division reference, plus backpressure and reset abort.
module tb_gf2m_reduce_409;

    localparam int CHUNK  = 68;
    localparam int NFOLD  = 408 / CHUNK;
    localparam int PW     = 817;
    localparam int MW     = 409;
    localparam int BOUND  = 60;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_prod;
    logic          out_valid;
    logic          out_ready;
    logic [MW-1:0] out_res;
    logic          busy;

    int compare_count;
    int fail_count;

    gf2m_reduce_409 #(
        .CHUNK (CHUNK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .busy      (busy)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Schoolbook reduction: clear each set bit from the top down and
    // add x^(i-409) + x^(i-322) in its place.
    function automatic logic [MW-1:0] refReduce(input logic [PW-1:0] c);
        logic [PW-1:0] r;
        r = c;
        for (int i = PW - 1; i >= MW; i--) begin
            if (r[i]) begin
                r[i]       = 1'b0;
                r[i - 409] = r[i - 409] ^ 1'b1;
                r[i - 322] = r[i - 322] ^ 1'b1;
            end
        end
        return r[MW-1:0];
    endfunction

    // Carry-less product of two 409-bit polynomials.
    function automatic logic [PW-1:0] clmul(input logic [MW-1:0] a,
                                            input logic [MW-1:0] b);
        logic [PW-1:0] p;
        p = '0;
        for (int i = 0; i < MW; i++)
            if (b[i]) p = p ^ (PW'(a) << i);
        return p;
    endfunction

    function automatic logic [PW-1:0] randProd();
        logic [831:0] w;
        for (int i = 0; i < 26; i++) w[i*32 +: 32] = $urandom;
        return w[PW-1:0];
    endfunction

    function automatic logic [MW-1:0] randElem();
        logic [415:0] w;
        for (int i = 0; i < 13; i++) w[i*32 +: 32] = $urandom;
        return w[MW-1:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [PW-1:0] observed,
                               input logic [PW-1:0] expected);
        compare_count++;
        assert (observed === expected)
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Presents one product in IDLE and checks that it is taken.
    task automatic applyStimulus(input string tag, input logic [PW-1:0] prod);
        int waited;
        waited = 0;
        while (in_ready !== 1'b1 && waited < BOUND) begin
            @(posedge clk); #1;
            waited++;
        end
        checkOutput({tag, "_in_ready"}, PW'(in_ready), PW'(1));
        in_valid = 1'b1;
        in_prod  = prod;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput({tag, "_busy"}, PW'({busy, in_ready}), PW'(2'b10));
    endtask

    // Counts edges after the accept edge until out_valid rises.
    task automatic waitDone(input string tag);
        int edges;
        edges = 0;
        while (out_valid !== 1'b1 && edges < BOUND) begin
            @(posedge clk); #1;
            edges++;
        end
        checkOutput({tag, "_latency"}, PW'(edges), PW'(NFOLD));
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput({tag, "_release"}, PW'({out_valid, in_ready, busy}), PW'(3'b010));
    endtask

    task automatic runOne(input string tag, input logic [PW-1:0] prod,
                          input logic [MW-1:0] expected);
        applyStimulus(tag, prod);
        waitDone(tag);
        checkOutput({tag, "_res"}, PW'(out_res), PW'(expected));
        handshake(tag);
    endtask

    initial begin
        logic [PW-1:0] p;
        logic [MW-1:0] e;
        logic [MW-1:0] a;
        logic [MW-1:0] b;
        bit            saw_valid;

        compare_count = 0;
        fail_count    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_prod   = '0;
        out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_flags", PW'({in_ready, out_valid, busy}), PW'(3'b100));
        checkOutput("reset_res", PW'(out_res), '0);
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] directed corner products");
        p = '0; p[0] = 1'b1;
        e = '0; e[0] = 1'b1;
        runOne("x0", p, e);

        p = '0; p[409] = 1'b1;
        e = '0; e[87] = 1'b1; e[0] = 1'b1;
        runOne("x409", p, e);

        p = '0; p[816] = 1'b1;
        e = '0; e[407] = 1'b1; e[172] = 1'b1; e[85] = 1'b1;
        runOne("x816", p, e);

        e = randElem();
        runOne("low_only", PW'(e), e);

        p = '1;
        runOne("all_ones", p, refReduce(p));

        $display("[TB] random products");
        for (int i = 0; i < 24; i++) begin
            p = randProd();
            runOne("rand", p, refReduce(p));
        end

        $display("[TB] random clmul products");
        for (int i = 0; i < 8; i++) begin
            a = randElem();
            b = randElem();
            p = clmul(a, b);
            runOne("clmul", p, refReduce(p));
        end

        $display("[TB] backpressure");
        p = randProd();
        e = refReduce(p);
        applyStimulus("bp", p);
        waitDone("bp");
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_prod  = randProd();
            @(posedge clk); #1;
            checkOutput("bp_hold_flags", PW'({out_valid, in_ready, busy}), PW'(3'b101));
            checkOutput("bp_hold_res", PW'(out_res), PW'(e));
        end
        in_valid = 1'b0;
        handshake("bp");
        @(posedge clk); #1;
        checkOutput("bp_no_start", PW'({in_ready, busy}), PW'(2'b10));

        $display("[TB] reset during fold");
        p = randProd();
        applyStimulus("rst", p);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("rst_flags", PW'({in_ready, out_valid, busy}), PW'(3'b100));
        checkOutput("rst_res", PW'(out_res), '0);
        saw_valid = 1'b0;
        for (int i = 0; i < NFOLD + 3; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) saw_valid = 1'b1;
        end
        checkOutput("rst_no_valid", PW'(saw_valid), '0);
        p = '0; p[409] = 1'b1;
        e = '0; e[87] = 1'b1; e[0] = 1'b1;
        runOne("after_rst", p, e);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end

endmodule
